// File: rtl/cplx_tile_pingpong_buf.sv
// Double-buffered complex tile store: a lane-packed writer fills one bank
// while a full-tile reader drains the other; banks swap on commit/release.
module cplx_tile_pingpong_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int TILE       = 4,
  parameter int WR_LANES   = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [ADDR_WIDTH-1:0]              wr_addr,
  input  logic [WR_LANES*2*DATA_WIDTH-1:0]   wr_data,
  input  logic                               wr_commit,
  output logic                               wr_bank,
  output logic                               rd_avail,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  output logic                               rd_valid,
  output logic [TILE*TILE*2*DATA_WIDTH-1:0]  rd_data,
  input  logic                               rd_release,
  output logic                               rd_bank,
  output logic                               err_partial
);

  localparam int CW    = 2 * DATA_WIDTH;
  localparam int EL    = TILE * TILE;
  localparam int BEATS = EL / WR_LANES;
  localparam int BW    = WR_LANES * CW;
  localparam int TW    = EL * CW;
  localparam int LW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((EL % WR_LANES) != 0) begin : g_bad_lanes
    $error("WR_LANES must divide TILE*TILE");
  end

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL
  } bank_st_e;

  bank_st_e        bank_q [2];
  bank_st_e        bank_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
  logic            err_q, err_d;
  logic            rd_valid_q, rd_valid_d;
  logic [TW-1:0]   rd_data_q, rd_data_d;
  logic [TW-1:0]   rd_tile;

  // One row per (bank, tile), one lane group per beat column.
  logic [BW-1:0]   mem [2*DEPTH][BEATS];

  logic wr_acc, commit, rd_fire, rel, last_beat;

  assign wr_ready  = (bank_q[wr_bank_q] != B_FULL);
  assign rd_avail  = (bank_q[rd_bank_q] == B_FULL);
  assign wr_acc    = wr_valid & wr_ready;
  assign commit    = wr_acc & wr_commit;
  assign rd_fire   = rd_en & rd_avail;
  assign rel       = rd_release & rd_avail;
  assign last_beat = (lane_cnt_q == LW'(BEATS - 1));

  always_comb begin
    rd_tile = '0;
    for (int b = 0; b < BEATS; b++) begin
      rd_tile[b*BW +: BW] = mem[{rd_bank_q, rd_addr}][b];
    end
  end

  always_comb begin
    bank_d[0]  = bank_q[0];
    bank_d[1]  = bank_q[1];
    wr_bank_d  = wr_bank_q ^ commit;
    rd_bank_d  = rd_bank_q ^ rel;
    lane_cnt_d = lane_cnt_q;
    err_d      = err_q | (commit & ~last_beat);
    rd_valid_d = rd_fire;
    rd_data_d  = rd_fire ? rd_tile : rd_data_q;
    // Writer never owns a FULL bank and reader only releases a FULL
    // one, so these two updates can never target the same bank.
    if (wr_acc) begin
      bank_d[wr_bank_q] = commit ? B_FULL : B_FILLING;
      if (commit || last_beat) lane_cnt_d = '0;
      else                     lane_cnt_d = lane_cnt_q + LW'(1);
    end
    if (rel) bank_d[rd_bank_q] = B_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q[0]  <= B_EMPTY;
      bank_q[1]  <= B_EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      lane_cnt_q <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      lane_cnt_q <= lane_cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[{wr_bank_q, wr_addr}][lane_cnt_q] <= wr_data;
  end

  assign wr_bank     = wr_bank_q;
  assign rd_bank     = rd_bank_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign err_partial = err_q;

endmodule
